exec_completion_buffer: RTL

Parametrised execute-stage completion buffer that lets the integer ALU and a multi-cycle pipelined FPU share one execute slot with in-order writeback. Decoded instructions enter over a valid/ready handshake with their sideband control bundle; ALU results are captured on entry, FPU operations are dispatched with a tag and filled in when the FPU returns. Entries retire strictly in issue order to the memory stage over a second valid/ready handshake with back-pressure.

---
 rtl/exec_completion_buffer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/exec_completion_buffer.sv
// ---------------------------------------------------------------------------
// exec_completion_buffer
//
// Execute-stage completion buffer shared by the integer ALU and a multi-cycle
// pipelined FPU. Instructions are issued in order into a circular buffer. ALU
// results are captured when the instruction is accepted. FPU operations are
// dispatched with their slot index as tag, and the result is written when the
// FPU reports completion. Entries retire strictly in issue order.
//
// Optional feature macro: EXEC_FLUSH_EN
//   When defined, a `flush` input is added. A flush empties the buffer. If FPU
//   operations are still in flight, a drain state holds off new issues and
//   discards their responses until every outstanding response has returned.
//
// Ports
//   CLK            clock, rising edge
//   reset          asynchronous reset, active low
//   flush          (EXEC_FLUSH_EN only) discard all entries
//   in_valid       issue request
//   in_ready       buffer can accept an issue
//   in_is_fpu      1 = FPU operation, 0 = ALU operation
//   in_side        opaque control bundle carried with the entry
//   in_alu_result  ALU result, used when !in_is_fpu
//   fpu_req_valid  FPU dispatch strobe (same cycle as the accept)
//   fpu_req_tag    slot index of the dispatched FPU operation
//   fpu_done       FPU completion strobe
//   fpu_done_tag   slot index being completed
//   fpu_result     FPU result
//   out_valid      head entry is complete
//   out_ready      downstream accepts the head entry
//   out_side       head control bundle
//   out_result     head result
//   out_is_fpu     head entry came from the FPU
//   fpu_pending    dispatched FPU operations not yet returned
// ---------------------------------------------------------------------------
module exec_completion_buffer #(
    parameter int  DEPTH      = 4,
    parameter int  SIDE_WIDTH = 48,
    parameter int  DATA_WIDTH = 32,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  reset,
`ifdef EXEC_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_fpu,
    input  logic [SIDE_WIDTH-1:0] in_side,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    output logic                  fpu_req_valid,
    output logic [PTR_W-1:0]      fpu_req_tag,
    input  logic                  fpu_done,
    input  logic [PTR_W-1:0]      fpu_done_tag,
    input  logic [DATA_WIDTH-1:0] fpu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIDE_WIDTH-1:0] out_side,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_is_fpu,
    output logic [PTR_W:0]        fpu_pending
);

    localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    // Pointers and occupancy
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        pending;
    logic [PTR_W:0]        pending_nxt;

    // Goes high on the first clock edge after reset is released; keeps
    // in_ready low while reset is held and during that first cycle.
    logic                  started;

    // Per-slot state
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      done_q;
    logic [DEPTH-1:0]      is_fpu_q;
    logic [SIDE_WIDTH-1:0] side_q   [DEPTH];
    logic [DATA_WIDTH-1:0] result_q [DEPTH];

    // Per-cycle events
    logic                  flush_now;
    logic                  draining;
    logic                  accept;
    logic                  retire;
    logic                  done_hit;
    logic                  pend_inc;
    logic                  pend_dec;

    // ------------------------------------------------------------------
    // Optional flush / drain control
    // ------------------------------------------------------------------
`ifdef EXEC_FLUSH_EN
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    drain_state_t state;
    drain_state_t state_nxt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Stay in drain until every tag issued before the flush has come back,
    // so a stale response can never land in a reused slot.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (flush && (pending_nxt != '0)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pending_nxt == '0) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign flush_now = flush;
    assign draining  = (state == ST_DRAIN);
`else
    assign flush_now = 1'b0;
    assign draining  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshakes and completion qualification
    // ------------------------------------------------------------------
    assign out_valid  = busy[head] && done_q[head];
    assign out_side   = side_q[head];
    assign out_result = result_q[head];
    assign out_is_fpu = is_fpu_q[head];

    // A full buffer refuses even when the head retires this cycle.
    assign in_ready = started && (count < CNT_DEPTH) && !draining;

    // A flush overrides any accept or retire in the same cycle.
    assign accept = in_valid && in_ready && !flush_now;
    assign retire = out_valid && out_ready && !flush_now;

    assign fpu_req_valid = accept && in_is_fpu;
    assign fpu_req_tag   = tail;

    // Only a busy slot still waiting for its result takes the FPU data.
    assign done_hit = fpu_done && busy[fpu_done_tag] && !done_q[fpu_done_tag]
                      && !draining;

    // Every response decrements the pending count, dropped or not, but the
    // count saturates at zero so responses after a reset are harmless.
    assign pend_inc    = fpu_req_valid;
    assign pend_dec    = fpu_done && (pending != '0);
    assign pending_nxt = pending + {{PTR_W{1'b0}}, pend_inc}
                                 - {{PTR_W{1'b0}}, pend_dec};
    assign fpu_pending = pending;

    // ------------------------------------------------------------------
    // Buffer state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pending  <= '0;
            started  <= 1'b0;
            busy     <= '0;
            done_q   <= '0;
            is_fpu_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                side_q[i]   <= '0;
                result_q[i] <= '0;
            end
        end else begin
            started <= 1'b1;
            pending <= pending_nxt;

            if (flush_now) begin
                busy   <= '0;
                done_q <= '0;
                head   <= '0;
                tail   <= '0;
                count  <= '0;
            end else begin
                // The completing slot is busy, so it is never the tail slot
                // being written by an accept in the same cycle.
                if (done_hit) begin
                    done_q[fpu_done_tag]   <= 1'b1;
                    result_q[fpu_done_tag] <= fpu_result;
                end

                if (retire) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end

                if (accept) begin
                    busy[tail]     <= 1'b1;
                    done_q[tail]   <= !in_is_fpu;
                    is_fpu_q[tail] <= in_is_fpu;
                    side_q[tail]   <= in_side;
                    if (!in_is_fpu) begin
                        result_q[tail] <= in_alu_result;
                    end
                    tail <= tail + 1'b1;
                end

                count <= count + {{PTR_W{1'b0}}, accept}
                               - {{PTR_W{1'b0}}, retire};
            end
        end
    end

endmodule
